// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback (A) has fixed priority over
// the long-latency writeback (B), with a starvation override and a pending-write scoreboard.
module regfile_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned XLEN         = 64
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_a_valid,
  input  logic [4:0]      i_a_rd,
  input  logic [XLEN-1:0] i_a_data,
  output logic            o_a_ready,
  input  logic            i_b_valid,
  input  logic [4:0]      i_b_rd,
  input  logic [XLEN-1:0] i_b_data,
  output logic            o_b_ready,
  input  logic            i_iss_valid,
  input  logic [4:0]      i_iss_rd,
  input  logic [4:0]      i_rs1,
  input  logic [4:0]      i_rs2,
  output logic            o_stall,
  output logic            o_wr_en,
  output logic [4:0]      o_wr_reg,
  output logic [XLEN-1:0] o_wr_data
);

  localparam logic [7:0] LP_LIMIT = 8'(STARVE_LIMIT);

  logic [7:0]      r_wait_cnt;
  logic [31:0]     r_busy;
  logic            r_wr_en;
  logic [4:0]      r_wr_reg;
  logic [XLEN-1:0] r_wr_data;

  logic            w_starved;
  logic            w_a_xfer;
  logic            w_b_xfer;
  logic [4:0]      w_rd;
  logic [XLEN-1:0] w_data;
  logic [31:0]     w_busy_nxt;

  assign w_starved = (r_wait_cnt == LP_LIMIT);
  assign o_a_ready = i_rst_n && i_a_valid && !(i_b_valid && w_starved);
  assign o_b_ready = i_rst_n && i_b_valid && (!i_a_valid || w_starved);
  assign w_a_xfer  = o_a_ready;
  assign w_b_xfer  = o_b_ready;
  assign w_rd      = w_b_xfer ? i_b_rd : i_a_rd;
  assign w_data    = w_b_xfer ? i_b_data : i_a_data;

  // Set after clear so a same-cycle reissue of the retiring rd stays pending.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_b_xfer) begin
      w_busy_nxt[i_b_rd] = 1'b0;
    end
    if (i_iss_valid && (i_iss_rd != 5'd0)) begin
      w_busy_nxt[i_iss_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wait_cnt <= 8'd0;
      r_busy     <= 32'd0;
      r_wr_en    <= 1'b0;
      r_wr_reg   <= 5'd0;
      r_wr_data  <= '0;
    end else begin
      if (!i_b_valid || w_b_xfer) begin
        r_wait_cnt <= 8'd0;
      end else if (!w_starved) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end
      r_busy <= w_busy_nxt;
      if (w_a_xfer || w_b_xfer) begin
        r_wr_en   <= (w_rd != 5'd0);
        r_wr_reg  <= w_rd;
        r_wr_data <= w_data;
      end else begin
        r_wr_en <= 1'b0;
      end
    end
  end

  // Stall reflects registered busy only; a clear this cycle lands with the write.
  assign o_stall = ((i_rs1 != 5'd0) && r_busy[i_rs1]) ||
                   ((i_rs2 != 5'd0) && r_busy[i_rs2]);

  assign o_wr_en   = r_wr_en;
  assign o_wr_reg  = r_wr_reg;
  assign o_wr_data = r_wr_data;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter with STARVE_LIMIT = 4, XLEN = 64.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        a_valid;
  logic [4:0]  a_rd;
  logic [63:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_rd;
  logic [63:0] b_data;
  logic        b_ready;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        stall;
  logic        wr_en;
  logic [4:0]  wr_reg;
  logic [63:0] wr_data;

  int n_cmp = 0;
  int n_err = 0;

  regfile_wb_arbiter #(.STARVE_LIMIT(4), .XLEN(64)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_valid(a_valid), .i_a_rd(a_rd), .i_a_data(a_data), .o_a_ready(a_ready),
    .i_b_valid(b_valid), .i_b_rd(b_rd), .i_b_data(b_data), .o_b_ready(b_ready),
    .i_iss_valid(iss_valid), .i_iss_rd(iss_rd), .i_rs1(rs1), .i_rs2(rs2),
    .o_stall(stall), .o_wr_en(wr_en), .o_wr_reg(wr_reg), .o_wr_data(wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 0; a_rd = 0; a_data = 0;
    b_valid = 0; b_rd = 0; b_data = 0;
    iss_valid = 0; iss_rd = 0; rs1 = 0; rs2 = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0; a_valid = 1; a_rd = 4; a_data = 64'h55;
    iss_valid = 1; iss_rd = 5; rs1 = 5;
    step(); step(); step();
    n_cmp++; if (a_ready !== 1'b0) begin n_err++; $display("FAIL reset_a_ready: got %b want 0", a_ready); end
    n_cmp++; if (b_ready !== 1'b0) begin n_err++; $display("FAIL reset_b_ready: got %b want 0", b_ready); end
    n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
    n_cmp++; if (wr_reg !== 5'd0) begin n_err++; $display("FAIL reset_wr_reg: got %0d want 0", wr_reg); end
    n_cmp++; if (wr_data !== 64'd0) begin n_err++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
    rst_n = 1; a_valid = 0; iss_valid = 0;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall); end
    step();
    n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en_after: got %b want 0", wr_en); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall_after: got %b want 0", stall); end
  endtask

  task automatic test_single_a();
    idle_inputs();
    a_valid = 1; a_rd = 3; a_data = 64'hDEAD_BEEF;
    #1;
    n_cmp++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL single_a_ready: got %b want 1", a_ready); end
    n_cmp++; if (b_ready !== 1'b0) begin n_err++; $display("FAIL single_b_ready: got %b want 0", b_ready); end
    step();
    a_valid = 0;
    n_cmp++; if (wr_en !== 1'b1) begin n_err++; $display("FAIL single_wr_en: got %b want 1", wr_en); end
    n_cmp++; if (wr_reg !== 5'd3) begin n_err++; $display("FAIL single_wr_reg: got %0d want 3", wr_reg); end
    n_cmp++; if (wr_data !== 64'hDEAD_BEEF) begin n_err++; $display("FAIL single_wr_data: got %h want deadbeef", wr_data); end
    step();
    n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL single_idle_wr_en: got %b want 0", wr_en); end
    n_cmp++; if (wr_reg !== 5'd3) begin n_err++; $display("FAIL single_hold_wr_reg: got %0d want 3", wr_reg); end
    n_cmp++; if (wr_data !== 64'hDEAD_BEEF) begin n_err++; $display("FAIL single_hold_wr_data: got %h want deadbeef", wr_data); end
  endtask

  // Both valid from an empty wait counter: A for 4 cycles, B on the 5th, then A again.
  task automatic test_starvation();
    logic exp_b [6];
    exp_b = '{0, 0, 0, 0, 1, 0};
    idle_inputs();
    a_valid = 1; a_rd = 10; a_data = 64'hA0A0;
    b_valid = 1; b_rd = 11; b_data = 64'hB0B0;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_cmp++; if (b_ready !== exp_b[i]) begin n_err++; $display("FAIL starve_b_ready[%0d]: got %b want %b", i, b_ready, exp_b[i]); end
      n_cmp++; if (a_ready !== !exp_b[i]) begin n_err++; $display("FAIL starve_a_ready[%0d]: got %b want %b", i, a_ready, !exp_b[i]); end
      step();
      n_cmp++; if (wr_reg !== (exp_b[i] ? 5'd11 : 5'd10)) begin n_err++; $display("FAIL starve_wr_reg[%0d]: got %0d want %0d", i, wr_reg, exp_b[i] ? 11 : 10); end
      n_cmp++; if (wr_data !== (exp_b[i] ? 64'hB0B0 : 64'hA0A0)) begin n_err++; $display("FAIL starve_wr_data[%0d]: got %h", i, wr_data); end
    end
    idle_inputs();
    step();
  endtask

  // A cycle with b_valid low must restart the starvation count from zero.
  task automatic test_wait_clear();
    idle_inputs();
    a_valid = 1; a_rd = 1; a_data = 64'h1;
    b_valid = 1; b_rd = 2; b_data = 64'h2;
    step(); step(); step();
    b_valid = 0;
    step();
    b_valid = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (b_ready !== (i == 4)) begin n_err++; $display("FAIL waitclr_b_ready[%0d]: got %b want %b", i, b_ready, i == 4); end
      step();
    end
    idle_inputs();
    step();
  endtask

  task automatic test_scoreboard();
    idle_inputs();
    iss_valid = 1; iss_rd = 7;
    step();
    iss_valid = 0; rs1 = 7;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL sb_stall_set: got %b want 1", stall); end
    step();
    rs1 = 0; rs2 = 7;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL sb_stall_rs2: got %b want 1", stall); end
    rs1 = 7; rs2 = 0;
    b_valid = 1; b_rd = 7; b_data = 64'h77;
    #1;
    n_cmp++; if (b_ready !== 1'b1) begin n_err++; $display("FAIL sb_b_ready: got %b want 1", b_ready); end
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL sb_stall_same_cycle: got %b want 1", stall); end
    step();
    b_valid = 0;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL sb_stall_cleared: got %b want 0", stall); end
    n_cmp++; if (wr_en !== 1'b1) begin n_err++; $display("FAIL sb_wr_en: got %b want 1", wr_en); end
    n_cmp++; if (wr_reg !== 5'd7) begin n_err++; $display("FAIL sb_wr_reg: got %0d want 7", wr_reg); end
    n_cmp++; if (wr_data !== 64'h77) begin n_err++; $display("FAIL sb_wr_data: got %h want 77", wr_data); end
    step();
  endtask

  task automatic test_simultaneous();
    idle_inputs();
    iss_valid = 1; iss_rd = 9;
    step();
    b_valid = 1; b_rd = 9; b_data = 64'h99;
    #1;
    n_cmp++; if (b_ready !== 1'b1) begin n_err++; $display("FAIL simul_b_ready: got %b want 1", b_ready); end
    step();
    iss_valid = 0; b_valid = 0; rs2 = 9;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL simul_stall: got %b want 1", stall); end
    n_cmp++; if (wr_reg !== 5'd9) begin n_err++; $display("FAIL simul_wr_reg: got %0d want 9", wr_reg); end
    b_valid = 1;
    step();
    b_valid = 0;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL simul_cleanup_stall: got %b want 0", stall); end
    step();
  endtask

  task automatic test_x0();
    idle_inputs();
    iss_valid = 1; iss_rd = 0;
    b_valid = 1; b_rd = 0; b_data = 64'h1234;
    #1;
    n_cmp++; if (b_ready !== 1'b1) begin n_err++; $display("FAIL x0_b_ready: got %b want 1", b_ready); end
    step();
    idle_inputs();
    #1;
    n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL x0_wr_en: got %b want 0", wr_en); end
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL x0_stall: got %b want 0", stall); end
    n_cmp++; if (wr_data !== 64'h1234) begin n_err++; $display("FAIL x0_wr_data: got %h want 1234", wr_data); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [4:0]  rds   [5];
    logic        use_b [5];
    rds   = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5};
    use_b = '{0, 0, 0, 1, 1};
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      a_valid = !use_b[i]; a_rd = rds[i]; a_data = 64'h100 + 64'(i);
      b_valid = use_b[i];  b_rd = rds[i]; b_data = 64'h200 + 64'(i);
      step();
      n_cmp++; if (wr_en !== 1'b1) begin n_err++; $display("FAIL b2b_wr_en[%0d]: got %b want 1", i, wr_en); end
      n_cmp++; if (wr_reg !== rds[i]) begin n_err++; $display("FAIL b2b_wr_reg[%0d]: got %0d want %0d", i, wr_reg, rds[i]); end
      n_cmp++; if (wr_data !== (use_b[i] ? 64'h200 : 64'h100) + 64'(i)) begin n_err++; $display("FAIL b2b_wr_data[%0d]: got %h", i, wr_data); end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    iss_valid = 1; iss_rd = 12;
    step();
    iss_valid = 0; rs1 = 12;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL rstmid_pre_stall: got %b want 1", stall); end
    rst_n = 0;
    step();
    rst_n = 1;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL rstmid_stall: got %b want 0", stall); end
    step();
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    test_reset();
    test_single_a();
    test_starvation();
    test_wait_clear();
    test_scoreboard();
    test_simultaneous();
    test_x0();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
